// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring divider for DIV/DIVU, fixed WIDTH+1 cycle latency
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  dvd;
    logic [WIDTH-1:0]  dvs;
    logic              sign_a;
    logic              sign_b;
    logic              sgn;
    logic              b_zero;
    logic              done_q;
    logic [WIDTH-1:0]  q_q;
    logic [WIDTH-1:0]  r_q;

    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH:0]    rem_sh;
    logic [WIDTH:0]    diff;
    logic              last_step;

    assign a_mag     = (div_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag     = (div_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign last_step = (cnt == LAST_STEP);

    // One restoring step: the shifted remainder needs WIDTH+1 bits; diff[WIDTH] is the borrow/sign.
    assign rem_sh = {rem, dvd[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_step) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = done_q;
        q    = q_q;
        r    = r_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            rem    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            sgn    <= 1'b0;
            b_zero <= 1'b0;
            done_q <= 1'b0;
            q_q    <= '0;
            r_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd    <= a_mag;
                        dvs    <= b_mag;
                        sign_a <= a[WIDTH-1];
                        sign_b <= b[WIDTH-1];
                        sgn    <= div_signed;
                        b_zero <= (b == '0);
                        rem    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    if (!diff[WIDTH]) begin
                        rem <= diff[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    // With b==0 every step keeps the shifted dividend, so rem==|a| and the
                    // usual sign fix-up restores the original a; only q needs forcing.
                    if (b_zero) begin
                        q_q <= '1;
                    end else if (sgn && (sign_a ^ sign_b)) begin
                        q_q <= ~dvd + 1'b1;
                    end else begin
                        q_q <= dvd;
                    end
                    r_q    <= (sgn && sign_a) ? (~rem + 1'b1) : rem;
                    done_q <= 1'b1;
                    cnt    <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed and randomized checks of div_iter against an arithmetic model
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        div_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;

    int checks;
    int passed;

    div_iter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .div_signed (div_signed),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .q          (q),
        .r          (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input bit ms,
                                  output logic [31:0] eq, output logic [31:0] er);
        longint sa;
        longint sb;
        longint tq;
        longint tr;
        if (mb == 32'd0) begin
            eq = 32'hFFFF_FFFF;
            er = ma;
        end else if (ms) begin
            sa = longint'($signed(ma));
            sb = longint'($signed(mb));
            tq = sa / sb;
            tr = sa % sb;
            eq = tq[31:0];
            er = tr[31:0];
        end else begin
            eq = ma / mb;
            er = ma % mb;
        end
    endfunction

    // Starts a division and follows it to completion; inj>0 pulses a second start at that busy cycle.
    task automatic run_div(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input bit ts, input int inj);
        logic [31:0] eq;
        logic [31:0] er;
        int n;
        model(ta, tb, ts, eq, er);
        @(negedge clk);
        a = ta;
        b = tb;
        div_signed = ts;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        div_signed = $urandom_range(0, 1);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == inj) begin
                start = 1'b1;
                a = 32'd5;
                b = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, 32'(n), 32'd33);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " q"}, q, eq);
        check({tag, " r"}, r, er);
        @(negedge clk);
        check({tag, " done_drop"}, {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check({tag, " busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int n;
        checks = 0;
        passed = 0;
        rst = 1'b0;
        start = 1'b0;
        div_signed = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset q", q, 32'd0);
        check("reset r", r, 32'd0);
        rst = 1'b1;

        run_div("u7_2", 32'd7, 32'd2, 1'b0, 0);
        run_div("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_div("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        run_div("s-7_-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 0);
        run_div("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_div("u_small", 32'h111, 32'h777, 1'b0, 0);
        run_div("u_div0", 32'h1234_5678, 32'd0, 1'b0, 0);
        run_div("s_div0", 32'h1234_5678, 32'd0, 1'b1, 0);
        run_div("s_div0_neg", 32'h8765_4321, 32'd0, 1'b1, 0);
        run_div("restart_ign", 32'd100, 32'd7, 1'b0, 10);
        check("restart_ign q14", q, 32'd14);
        check("restart_ign r2", r, 32'd2);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 3) == 0) rb = -rb;
            run_div($sformatf("rand%0d", i), ra, rb, bit'($urandom_range(0, 1)), 0);
        end

        // Reset in the middle of a division: outputs clear at once and no result follows.
        @(negedge clk);
        a = 32'd1000;
        b = 32'd3;
        div_signed = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 15) begin
            n++;
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst done", {31'd0, done}, 32'd0);
        check("midrst q", q, 32'd0);
        check("midrst r", r, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n++;
        end
        check("midrst no_result", 32'(n), 32'd0);
        run_div("post_rst 9_3", 32'd9, 32'd3, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
